coreabc_acm_ram: RTL

Programmable, registered ACM lookup table for the CoreABC APB controller. The ACM decode path gets a synchronous lookup port with a per-entry valid bit. The table is loaded at run time through a small APB slave, so the ACM contents no longer have to be fixed when the design is built. A walk sequencer clears the whole table on command and, optionally, preloads the test pattern after reset.

---
 rtl/coreabc_acm_ram.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/coreabc_acm_ram.sv
`default_nettype none
// ============================================================================
// Module   : coreabc_acm_ram
// Brief    : APB-loadable ACM lookup table with a registered lookup port,
//            per-entry valid bits and a clear/init walk sequencer.
//            Optional test-pattern preload after reset: ACMTABLE_TESTMODE_EN
// Revision : 1.0
// ============================================================================
module coreabc_acm_ram #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ACMREQ,
  input  logic [AWIDTH-1:0] ACMADDR,
  output logic              ACMVALID,
  output logic [DWIDTH-1:0] ACMDATA,
  output logic              ACMDO,
  output logic              BUSY
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH-1:0] c_last = {AWIDTH{1'b1}};

`ifdef ACMTABLE_TESTMODE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_INIT = 2'd2} state_t;
  localparam state_t c_rst_state = S_INIT;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1} state_t;
  localparam state_t c_rst_state = S_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] r_ptr;
  logic [DEPTH-1:0]  r_vld;
  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic              r_acm_valid;
  logic              r_acm_do;
  logic [DWIDTH-1:0] r_acm_data;

  logic              w_access;
  logic              w_sel_ptr;
  logic              w_sel_data;
  logic              w_sel_ctrl;
  logic              w_unmapped;
  logic              w_wr;
  logic              w_ptr_wr;
  logic              w_data_wr;
  logic              w_ctrl_start;
  logic              w_busy;
  logic              w_init;
  logic              w_cnt_last;
  logic [AWIDTH-1:0] w_cnt_inv;
  logic [DWIDTH-1:0] w_walk_data;
  logic              w_walk_vld;
  logic [DWIDTH-1:0] w_ptr_data;
  logic              w_hit;
  logic              w_unused;

  assign w_access     = PSEL & PENABLE;
  assign w_sel_ptr    = (PADDR == 4'h0);
  assign w_sel_data   = (PADDR == 4'h4);
  assign w_sel_ctrl   = (PADDR == 4'h8);
  assign w_unmapped   = ~(w_sel_ptr | w_sel_data | w_sel_ctrl);
  assign w_busy       = (r_state != S_IDLE);

  // DATA accesses stall while a walk owns the array; PTR/CTRL never stall.
  assign PREADY       = ~(w_access & w_sel_data & w_busy);
  assign PSLVERR      = w_access & w_unmapped;
  assign w_wr         = w_access & PWRITE & PREADY;
  assign w_ptr_wr     = w_wr & w_sel_ptr;
  assign w_data_wr    = w_wr & w_sel_data;
  assign w_ctrl_start = w_wr & w_sel_ctrl & PWDATA[0];

`ifdef ACMTABLE_TESTMODE_EN
  assign w_init = (r_state == S_INIT);
`else
  assign w_init = 1'b0;
`endif

  assign w_cnt_last  = (r_cnt == c_last);
  assign w_cnt_inv   = ~r_cnt;
  assign w_walk_data = w_init ? DWIDTH'(w_cnt_inv) : '0;
  // Entry 100 stays invalid in the preload pattern so a miss can be observed.
  assign w_walk_vld  = w_init & (32'(r_cnt) != 32'd100);
  assign w_ptr_data  = r_vld[r_ptr] ? r_mem[r_ptr] : '0;
  assign w_hit       = ACMREQ & ~w_busy & r_vld[ACMADDR];
  assign w_unused    = ^PWDATA;

  always_comb begin
    PRDATA = '0;
    if (w_access && !PWRITE) begin
      if (w_sel_ptr)       PRDATA = 32'(r_ptr);
      else if (w_sel_data) PRDATA = 32'(w_ptr_data);
      else if (w_sel_ctrl) PRDATA = {30'd0, w_init, w_busy};
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_rst_state;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) r_cnt <= r_cnt + AWIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ctrl_start) w_state_nxt = S_CLEAR;
      default: if (w_cnt_last)   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_vld <= '0;
    end else if (w_busy) begin
      r_vld[r_cnt] <= w_walk_vld;
    end else if (w_data_wr) begin
      r_vld[r_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_ptr <= '0;
    end else if (w_ptr_wr) begin
      r_ptr <= PWDATA[AWIDTH-1:0];
    end else if (w_data_wr) begin
      r_ptr <= r_ptr + AWIDTH'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_busy) begin
      r_mem[r_cnt] <= w_walk_data;
    end else if (w_data_wr) begin
      r_mem[r_ptr] <= PWDATA[DWIDTH-1:0];
    end
  end

  // The array read here sees pre-write contents on a same-cycle DATA write.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      r_acm_valid <= 1'b0;
      r_acm_do    <= 1'b0;
      r_acm_data  <= '0;
    end else begin
      r_acm_valid <= ACMREQ;
      r_acm_do    <= w_hit;
      r_acm_data  <= w_hit ? r_mem[ACMADDR] : '0;
    end
  end

  assign ACMVALID = r_acm_valid;
  assign ACMDO    = r_acm_do;
  assign ACMDATA  = r_acm_data;
  assign BUSY     = w_busy;

endmodule
`default_nettype wire
